// File: rtl/maze_move_ctrl.sv
// maze_move_ctrl: sequencer between the raw push-buttons and the maze data block.
// Each button passes through a synchronizer, a debouncer and an edge detector.
// Direction presses are arbitrated with the priority U > D > L > R.
// The FSM then issues single-cycle start/store/move/judge commands, counts the
// moves made and holds the win flag.
// Optional build macro MAZE_MOVE_CTRL_TIMER_EN adds the elapsed_s play timer
// and its TICK_CYCLES parameter.
module maze_move_ctrl #(
    parameter int DEB_CYCLES  = 1000000,
    parameter int DEB_W       = 20,
    parameter int STEP_W      = 10,
`ifdef MAZE_MOVE_CTRL_TIMER_EN
    parameter int TICK_CYCLES = 100000000,
`endif
    parameter int JUDGE_WIN   = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              btn_start,
    input  logic              btn_store,
    input  logic              btn_u,
    input  logic              btn_d,
    input  logic              btn_l,
    input  logic              btn_r,
    input  logic              move_able,
    input  logic              judge_able,
    output logic              start,
    output logic              store,
    output logic              move,
    output logic              judge,
    output logic              U,
    output logic              D,
    output logic              L,
    output logic              R,
    output logic [STEP_W-1:0] step_cnt,
    output logic              win,
`ifdef MAZE_MOVE_CTRL_TIMER_EN
    output logic [9:0]        elapsed_s,
`endif
    output logic              busy
);

    localparam int                WIN_W    = $clog2(JUDGE_WIN + 1);
    localparam logic [DEB_W-1:0]  DEB_LAST = DEB_W'(DEB_CYCLES - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    typedef enum logic [3:0] {
        S_IDLE, S_INIT, S_READY, S_STORE, S_DIR,
        S_MOVE, S_JUDGE, S_JWAIT, S_DONE
    } state_t;

    state_t            state_reg;
    logic [3:0]        dir_reg;      // {R, L, D, U}
    logic [WIN_W-1:0]  win_cnt_reg;
    logic [5:0]        btn_raw;      // {r, l, d, u, store, start}
    logic [5:0]        edge_req;
    logic [3:0]        dir_sel;

    assign btn_raw = {btn_r, btn_l, btn_d, btn_u, btn_store, btn_start};

    genvar gi;
    generate
        for (gi = 0; gi < 6; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             deb_reg;
            logic             deb_d_reg;
            logic [DEB_W-1:0] deb_cnt_reg;

            // Synchronize, then only accept a level that stays stable for DEB_CYCLES.
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    deb_reg     <= 1'b0;
                    deb_d_reg   <= 1'b0;
                    deb_cnt_reg <= '0;
                end else begin
                    sync1_reg <= btn_raw[gi];
                    sync2_reg <= sync1_reg;
                    deb_d_reg <= deb_reg;
                    if (sync2_reg == deb_reg) begin
                        deb_cnt_reg <= '0;
                    end else if (deb_cnt_reg == DEB_LAST) begin
                        deb_reg     <= sync2_reg;
                        deb_cnt_reg <= '0;
                    end else begin
                        deb_cnt_reg <= deb_cnt_reg + 1'b1;
                    end
                end
            end

            assign edge_req[gi] = deb_reg & ~deb_d_reg;
        end
    endgenerate

    // Fixed-priority pick among same-cycle direction edges; losers are dropped.
    always_comb begin
        dir_sel = 4'b0000;
        if (edge_req[2])      dir_sel = 4'b0001;
        else if (edge_req[3]) dir_sel = 4'b0010;
        else if (edge_req[4]) dir_sel = 4'b0100;
        else if (edge_req[5]) dir_sel = 4'b1000;
    end

    // Main sequencer: command pulses are asserted on entry to their one-cycle states.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_reg   <= S_IDLE;
            start       <= 1'b0;
            store       <= 1'b0;
            move        <= 1'b0;
            judge       <= 1'b0;
            dir_reg     <= 4'b0000;
            step_cnt    <= '0;
            win         <= 1'b0;
            win_cnt_reg <= '0;
        end else begin
            start <= 1'b0;
            store <= 1'b0;
            move  <= 1'b0;
            judge <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (edge_req[0]) begin
                        state_reg <= S_INIT;
                        start     <= 1'b1;
                        step_cnt  <= '0;
                        win       <= 1'b0;
                    end
                end
                S_INIT: state_reg <= S_READY;
                S_READY: begin
                    if (edge_req[0]) begin
                        state_reg <= S_INIT;
                        start     <= 1'b1;
                        step_cnt  <= '0;
                        win       <= 1'b0;
                    end else if (edge_req[1]) begin
                        state_reg <= S_STORE;
                        store     <= 1'b1;
                    end else if (dir_sel != 4'b0000) begin
                        state_reg <= S_DIR;
                        dir_reg   <= dir_sel;
                    end
                end
                S_STORE: state_reg <= S_READY;
                S_DIR: begin
                    if (move_able) begin
                        state_reg <= S_MOVE;
                        move      <= 1'b1;
                        if (step_cnt != STEP_MAX) step_cnt <= step_cnt + 1'b1;
                    end else begin
                        state_reg <= S_READY;
                        dir_reg   <= 4'b0000;
                    end
                end
                S_MOVE: begin
                    state_reg <= S_JUDGE;
                    judge     <= 1'b1;
                end
                S_JUDGE: begin
                    state_reg   <= S_JWAIT;
                    win_cnt_reg <= WIN_W'(JUDGE_WIN);
                end
                S_JWAIT: begin
                    if (judge_able) begin
                        state_reg <= S_DONE;
                        win       <= 1'b1;
                        dir_reg   <= 4'b0000;
                    end else if (win_cnt_reg == '0) begin
                        state_reg <= S_READY;
                        dir_reg   <= 4'b0000;
                    end else begin
                        win_cnt_reg <= win_cnt_reg - 1'b1;
                    end
                end
                S_DONE: begin
                    if (edge_req[0]) begin
                        state_reg <= S_INIT;
                        start     <= 1'b1;
                        step_cnt  <= '0;
                        win       <= 1'b0;
                    end
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign U = dir_reg[0];
    assign D = dir_reg[1];
    assign L = dir_reg[2];
    assign R = dir_reg[3];

    // Busy whenever a command sequence is in flight.
    assign busy = (state_reg != S_IDLE) && (state_reg != S_READY) && (state_reg != S_DONE);

`ifdef MAZE_MOVE_CTRL_TIMER_EN
    localparam int TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    logic [TICK_W-1:0] tick_cnt_reg;
    logic              timer_run;

    assign timer_run = (state_reg == S_READY) || (state_reg == S_STORE) ||
                       (state_reg == S_DIR)   || (state_reg == S_MOVE)  ||
                       (state_reg == S_JUDGE) || (state_reg == S_JWAIT);

    // Seconds counter: cleared on (re)load, frozen outside play, saturating.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            tick_cnt_reg <= '0;
            elapsed_s    <= '0;
        end else if (state_reg == S_INIT) begin
            tick_cnt_reg <= '0;
            elapsed_s    <= '0;
        end else if (timer_run) begin
            if (tick_cnt_reg == TICK_W'(TICK_CYCLES - 1)) begin
                tick_cnt_reg <= '0;
                if (elapsed_s != 10'd1023) elapsed_s <= elapsed_s + 1'b1;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
        end
    end
`endif

endmodule
